// File: rtl/icache_fetch_if.sv
// rtl/icache_fetch_if.sv - instruction queue and memory bus bundle for icache_fetch
//
// Ports (signals)
//   is_exception_from_rob  flush from the ROB
//   is_empty_from_iq       0 = fetch request valid at pc_from_iq
//   pc_from_iq             word-aligned fetch address
//   is_hit_to_iq           one-cycle pulse, instr_to_iq valid
//   instr_to_iq            fetched instruction word
//   mem_din                memory read byte, one cycle after mem_a
//   mem_a                  memory byte address
//   mem_wr                 memory write enable, always 0
// Modports: slave = cache side, master = requester/memory side.

interface icache_fetch_if #(
    parameter int PcWidth = 32
);
    logic               is_exception_from_rob;
    logic               is_empty_from_iq;
    logic [PcWidth-1:0] pc_from_iq;
    logic               is_hit_to_iq;
    logic [31:0]        instr_to_iq;
    logic [7:0]         mem_din;
    logic [PcWidth-1:0] mem_a;
    logic               mem_wr;

    modport slave (
        input  is_exception_from_rob,
        input  is_empty_from_iq,
        input  pc_from_iq,
        input  mem_din,
        output is_hit_to_iq,
        output instr_to_iq,
        output mem_a,
        output mem_wr
    );

    modport master (
        output is_exception_from_rob,
        output is_empty_from_iq,
        output pc_from_iq,
        output mem_din,
        input  is_hit_to_iq,
        input  instr_to_iq,
        input  mem_a,
        input  mem_wr
    );
endinterface

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped instruction cache fetch unit
//
// One 32-bit word per line, 2**IndexWidth lines. A request seen in IDLE is
// looked up immediately; a hit pulses is_hit_to_iq on the next cycle, a miss
// reads the word byte by byte (little-endian) from memory, fills the line and
// then pulses. Every pulse is followed by two HOLD cycles that ignore requests.
//
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  icache_fetch_if.slave: flush, IQ request/response, memory byte port

module icache_fetch #(
    parameter int IndexWidth = 6,
    parameter int PcWidth    = 32
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave bus
);

    localparam int Lines    = 2 ** IndexWidth;
    localparam int TagWidth = PcWidth - IndexWidth - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    // Counts byte slots while in FETCH (0..4) and hold cycles in HOLD (0..1).
    logic [2:0]         cnt_q, cnt_d;
    logic [PcWidth-1:0] pc_q, pc_d;
    logic [31:0]        buf_q, buf_d;
    logic               hit_q, hit_d;
    logic [31:0]        instr_q, instr_d;
    logic [Lines-1:0]   valid_q, valid_d;

    // Data and tag storage carry no reset; only the valid bits matter.
    logic [31:0]         data_mem [Lines];
    logic [TagWidth-1:0] tag_mem  [Lines];

    logic                  line_we;
    logic [31:0]           line_wdata;
    logic [IndexWidth-1:0] req_idx;
    logic [TagWidth-1:0]   req_tag;
    logic [IndexWidth-1:0] fill_idx;
    logic [TagWidth-1:0]   fill_tag;
    logic                  lookup_hit;

    assign req_idx    = bus.pc_from_iq[IndexWidth+1:2];
    assign req_tag    = bus.pc_from_iq[PcWidth-1:IndexWidth+2];
    assign fill_idx   = pc_q[IndexWidth+1:2];
    assign fill_tag   = pc_q[PcWidth-1:IndexWidth+2];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        hit_d      = 1'b0;
        instr_d    = instr_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        line_wdata = buf_q;

        if (bus.is_exception_from_rob) begin
            // Flush wins over everything, including a same-cycle request and
            // the final fill edge, so the target line is never written.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.is_empty_from_iq) begin
                        pc_d  = bus.pc_from_iq;
                        cnt_d = '0;
                        if (lookup_hit) begin
                            hit_d   = 1'b1;
                            instr_d = data_mem[req_idx];
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    // mem_din lags the address by one cycle, so slot k holds
                    // the byte for pc+k-1.
                    case (cnt_q)
                        3'd1:    buf_d[7:0]   = bus.mem_din;
                        3'd2:    buf_d[15:8]  = bus.mem_din;
                        3'd3:    buf_d[23:16] = bus.mem_din;
                        3'd4:    buf_d[31:24] = bus.mem_din;
                        default: ;
                    endcase
                    if (cnt_q == 3'd4) begin
                        line_we           = 1'b1;
                        line_wdata        = buf_d;
                        valid_d[fill_idx] = 1'b1;
                        hit_d             = 1'b1;
                        instr_d           = buf_d;
                        state_d           = ST_HOLD;
                        cnt_d             = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            buf_q   <= '0;
            hit_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            hit_q   <= hit_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[fill_idx] <= line_wdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // Address is issued for the first four FETCH cycles only; it derives from
    // reset flops, so it drops to zero as soon as reset or a flush lands.
    assign bus.mem_a        = ((state_q == ST_FETCH) && (cnt_q < 3'd4))
                              ? (pc_q + PcWidth'(cnt_q)) : '0;
    assign bus.mem_wr       = 1'b0;
    assign bus.is_hit_to_iq = hit_q;
    assign bus.instr_to_iq  = instr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - self-checking bench for icache_fetch
module tb_icache_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_fetch_if #(.PcWidth(32)) bus ();

    icache_fetch #(.IndexWidth(6), .PcWidth(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem_arr [4096];
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] last_word;

    // Memory: address seen in one cycle, byte returned for the next cycle.
    initial begin : mem_model
        logic [31:0] a_s;
        bus.mem_din = 8'h00;
        forever begin
            @(negedge clk);
            a_s = bus.mem_a;
            @(posedge clk);
            #1;
            bus.mem_din = mem_arr[a_s[11:0]];
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] w;
        logic [31:0] a;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            w[8*k +: 8] = mem_arr[a[11:0]];
        end
        return w;
    endfunction

    function automatic logic model_hit(input logic [31:0] pc);
        logic [5:0]  idx;
        logic [23:0] tg;
        idx = pc[7:2];
        tg  = pc[31:8];
        return m_valid[idx] && (m_tag[idx] == tg);
    endfunction

    // Issue one request at the current negedge and check 8 cycles of outputs.
    task automatic do_fetch(input logic [31:0] pc, input string name);
        logic        exp_hit;
        logic [31:0] exp_word;
        logic [31:0] exp_a;
        logic [5:0]  idx;
        int          exp_cyc;
        idx      = pc[7:2];
        exp_hit  = model_hit(pc);
        exp_word = exp_hit ? m_data[idx] : mem_word(pc);
        exp_cyc  = exp_hit ? 1 : 6;
        bus.is_empty_from_iq = 1'b0;
        bus.pc_from_iq       = pc;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.is_empty_from_iq = 1'b1;
                bus.pc_from_iq       = $urandom;
            end
            exp_a = (!exp_hit && k <= 4) ? pc + 32'(k - 1) : 32'h0;
            n_tests++;
            if (bus.mem_a !== exp_a) begin
                n_fail++;
                $display("FAIL %s mem_a cyc%0d got %h exp %h", name, k, bus.mem_a, exp_a);
            end
            n_tests++;
            if (bus.is_hit_to_iq !== (k == exp_cyc)) begin
                n_fail++;
                $display("FAIL %s hit cyc%0d got %b exp %b", name, k, bus.is_hit_to_iq, (k == exp_cyc));
            end
            if (k == exp_cyc || k == 8) begin
                n_tests++;
                if (bus.instr_to_iq !== exp_word) begin
                    n_fail++;
                    $display("FAIL %s instr cyc%0d got %h exp %h", name, k, bus.instr_to_iq, exp_word);
                end
            end
            n_tests++;
            if (bus.mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL %s mem_wr cyc%0d got %b exp 0", name, k, bus.mem_wr);
            end
        end
        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc[31:8];
            m_data[idx]  = exp_word;
        end
        last_word = exp_word;
    endtask

    // Request pc with a flush in cycle N+abort_k (0 = same cycle as request).
    // Non-zero abort_k is only used for PCs the model reports as misses.
    task automatic abort_fetch(input logic [31:0] pc, input int abort_k, input string name);
        logic [31:0] exp_a;
        bus.is_empty_from_iq      = 1'b0;
        bus.pc_from_iq            = pc;
        bus.is_exception_from_rob = (abort_k == 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.is_empty_from_iq = 1'b1;
                bus.pc_from_iq       = $urandom;
            end
            exp_a = (k <= abort_k && k <= 4) ? pc + 32'(k - 1) : 32'h0;
            n_tests++;
            if (bus.mem_a !== exp_a) begin
                n_fail++;
                $display("FAIL %s mem_a cyc%0d got %h exp %h", name, k, bus.mem_a, exp_a);
            end
            n_tests++;
            if (bus.is_hit_to_iq !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hit cyc%0d got %b exp 0", name, k, bus.is_hit_to_iq);
            end
            n_tests++;
            if (bus.instr_to_iq !== last_word) begin
                n_fail++;
                $display("FAIL %s instr_hold cyc%0d got %h exp %h", name, k, bus.instr_to_iq, last_word);
            end
            bus.is_exception_from_rob = (k == abort_k);
        end
        bus.is_exception_from_rob = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.is_exception_from_rob = 1'b0;
        bus.is_empty_from_iq      = 1'b1;
        bus.pc_from_iq            = '0;
        last_word                 = '0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.is_hit_to_iq !== 1'b0) begin n_fail++; $display("FAIL reset hit got %b exp 0", bus.is_hit_to_iq); end
        n_tests++;
        if (bus.instr_to_iq !== 32'h0) begin n_fail++; $display("FAIL reset instr got %h exp 0", bus.instr_to_iq); end
        n_tests++;
        if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset mem_a got %h exp 0", bus.mem_a); end
        n_tests++;
        if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset mem_wr got %b exp 0", bus.mem_wr); end
        rst = 1'b1;
    endtask

    task automatic test_cold_miss;
        do_fetch(32'h0000_0010, "cold_miss");
        n_tests++;
        if (last_word !== 32'h0000_0513) begin
            n_fail++;
            $display("FAIL cold_miss word got %h exp 00000513", last_word);
        end
    endtask

    task automatic test_warm_hit;
        do_fetch(32'h0000_0010, "warm_hit");
    endtask

    task automatic test_conflict;
        do_fetch(32'h0000_0110, "conflict_fill");
        do_fetch(32'h0000_0010, "conflict_refetch");
    endtask

    task automatic test_flush_mid_fetch;
        abort_fetch(32'h0000_0020, 3, "flush_n3");
        do_fetch(32'h0000_0020, "flush_refetch");
        abort_fetch(32'h0000_0110, 5, "flush_fill_edge");
        do_fetch(32'h0000_0010, "flush_line_kept");
        abort_fetch(32'h0000_0010, 0, "flush_same_cycle");
        do_fetch(32'h0000_0010, "after_same_cycle");
    endtask

    task automatic test_reset_mid_fetch;
        bus.is_empty_from_iq = 1'b0;
        bus.pc_from_iq       = 32'h0000_0030;
        @(negedge clk);
        bus.is_empty_from_iq = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.mem_a !== 32'h0000_0031) begin n_fail++; $display("FAIL rst_mid pre mem_a got %h exp 00000031", bus.mem_a); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mid mem_a got %h exp 0", bus.mem_a); end
        n_tests++;
        if (bus.instr_to_iq !== 32'h0) begin n_fail++; $display("FAIL rst_mid instr got %h exp 0", bus.instr_to_iq); end
        n_tests++;
        if (bus.is_hit_to_iq !== 1'b0) begin n_fail++; $display("FAIL rst_mid hit got %b exp 0", bus.is_hit_to_iq); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        last_word = '0;
        do_fetch(32'h0000_0010, "rst_mid_recached_miss");
        do_fetch(32'h0000_0030, "rst_mid_target_miss");
    endtask

    task automatic test_back_to_back;
        logic prev_hit;
        logic exp;
        do_fetch(32'h0000_0010, "b2b_prime");
        prev_hit = 1'b0;
        bus.is_empty_from_iq = 1'b0;
        bus.pc_from_iq       = 32'h0000_0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k % 3 == 1);
            n_tests++;
            if (bus.is_hit_to_iq !== exp) begin
                n_fail++;
                $display("FAIL b2b hit cyc%0d got %b exp %b", k, bus.is_hit_to_iq, exp);
            end
            n_tests++;
            if (prev_hit && bus.is_hit_to_iq) begin
                n_fail++;
                $display("FAIL b2b adjacent pulses at cyc%0d got 1 exp 0", k);
            end
            prev_hit = bus.is_hit_to_iq;
        end
        bus.is_empty_from_iq = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pc_wrap;
        do_fetch(32'hFFFF_FFFC, "wrap_miss");
        do_fetch(32'hFFFF_FFFC, "wrap_hit");
    endtask

    task automatic test_random;
        logic [31:0] pc;
        for (int i = 0; i < 30; i++) begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if (!model_hit(pc) && $urandom_range(0, 3) == 0)
                abort_fetch(pc, int'($urandom_range(0, 5)), "rand_abort");
            else
                do_fetch(pc, "rand_fetch");
        end
    endtask

    initial begin : main
        for (int i = 0; i < 4096; i++) mem_arr[i] = 8'($urandom);
        mem_arr[12'h010] = 8'h13;
        mem_arr[12'h011] = 8'h05;
        mem_arr[12'h012] = 8'h00;
        mem_arr[12'h013] = 8'h00;
        test_reset;
        test_cold_miss;
        test_warm_hit;
        test_conflict;
        test_flush_mid_fetch;
        test_reset_mid_fetch;
        test_back_to_back;
        test_pc_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter IndexWidth, default 6: cache index bits; line count = 2^IndexWidth, one 32-bit word per line.
REQ-002 Parameter PcWidth, default 32: width of all PC and memory address buses.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 is_exception_from_rob  input  1  flush; abort any in-flight request.
REQ-006 is_empty_from_iq  input  1  0 = fetch request valid at pc_from_iq.
REQ-007 pc_from_iq  input  PcWidth  word-aligned fetch address.
REQ-008 is_hit_to_iq  output  1  one-cycle pulse: instr_to_iq is valid for the requested PC.
REQ-009 instr_to_iq  output  32  fetched instruction word.
REQ-010 mem_din  input  8  memory read byte, valid one cycle after the address is driven.
REQ-011 mem_a  output  PcWidth  memory byte address.
REQ-012 mem_wr  output  1  memory write enable; tied to 0.

Function
REQ-013 The block SHALL be direct-mapped: index = pc[IndexWidth+1:2], tag = pc[PcWidth-1:IndexWidth+2], plus one valid bit per line.
REQ-014 The FSM SHALL have states IDLE, FETCH, HOLD.
REQ-015 In IDLE, a request (is_empty_from_iq=0) SHALL be sampled at the clock edge; pc is latched internally.
REQ-016 Hit case: a request in cycle N with valid and tag match SHALL produce is_hit_to_iq=1 and instr_to_iq=line data in cycle N+1 only, then enter HOLD.
REQ-017 Miss case: a request in cycle N with no match SHALL enter FETCH and drive mem_a = pc, pc+1, pc+2, pc+3 in cycles N+1..N+4.
REQ-018 A 3-bit byte counter SHALL capture mem_din little-endian: the byte for pc+k goes to bits [8k+7:8k].
REQ-019 On a miss, the block SHALL write the line (data, tag, valid=1) and pulse is_hit_to_iq with the assembled word in cycle N+6, then enter HOLD.
REQ-020 HOLD SHALL last exactly 2 cycles, during which requests are ignored, then return to IDLE.
REQ-021 mem_a SHALL be 0 whenever FETCH is not issuing; mem_wr SHALL be 0 always.
REQ-022 is_hit_to_iq SHALL never be high for 2 consecutive cycles.
REQ-023 instr_to_iq SHALL hold its last value when is_hit_to_iq=0.
REQ-024 Exception precedence: is_exception_from_rob=1 at any edge SHALL force IDLE next cycle, clear the byte counter, suppress any pending hit pulse and drive mem_a=0.
REQ-025 An exception during FETCH SHALL leave the target line unmodified.
REQ-026 The valid array SHALL survive exceptions; only reset clears it.
REQ-027 A request in the same cycle as an exception SHALL be discarded.
REQ-028 PC arithmetic SHALL wrap modulo 2^PcWidth; index wrap at the top line SHALL need no special case.

Reset
REQ-029 While rst=0, asynchronously: all valid bits=0, state=IDLE, counter=0, is_hit_to_iq=0, instr_to_iq=0, mem_a=0, mem_wr=0.
REQ-030 Reset asserted mid-FETCH SHALL abort the fetch with no line written.
REQ-031 After rst rises, the first request SHALL be accepted at the first rising edge.

Verification
REQ-032 Cold miss: after reset, request pc=0x00000010 in cycle N, memory bytes 0x13,0x05,0x00,0x00 -> mem_a 0x10..0x13 in N+1..N+4; hit pulse in N+6 with instr 0x00000513.
REQ-033 Warm hit: re-request 0x10 after HOLD -> hit pulse one cycle later with 0x00000513 and mem_a stays 0.
REQ-034 Conflict: request 0x00000110 (same index, new tag) -> refetch from 0x110; a subsequent request to 0x10 misses again.
REQ-035 Flush mid-fetch: exception in cycle N+3 of a miss to 0x20 -> no hit pulse, IDLE at N+4; a later request to 0x20 refetches all 4 bytes.
REQ-036 Reset mid-fetch: rst=0 during FETCH -> outputs zero immediately; after release, a request to a previously cached PC misses.
REQ-037 HOLD: back-to-back requests with is_empty_from_iq held low -> hit pulses at least 3 cycles apart, never in adjacent cycles.
